// File: rtl/usb_pkg.sv
// Shared constants and state encodings for the EP0IN ping-pong feeder and the
// slave-FIFO controller that consumes its pkt_* interface.
package usb_pkg;
    localparam int DATA_W    = 32;
    localparam int PKT_WORDS = 1024;
    localparam int ADDR_W    = $clog2(PKT_WORDS);
    localparam int LEN_W     = $clog2(PKT_WORDS + 1);

    typedef enum logic [1:0] {
        W_EMPTY,
        W_FILL,
        W_BLOCK
    } w_state_t;

    typedef enum logic {
        R_EMPTY,
        R_AVAIL
    } r_state_t;
endpackage

// File: rtl/usb_sdp_ram.sv
// Simple dual-port RAM with a registered, enable-gated read port.
// No reset on storage or read register so the tools can map it to block RAM.
module usb_sdp_ram #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 11
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               re,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);
    logic [DATA_W-1:0] mem [0:(1 << DEPTH_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/usb_tx_pingpong.sv
// Ping-pong packet buffer feeding the FX3 EP0IN path: one bank fills from the
// source stream while the other is drained by the USB writer.
module usb_tx_pingpong
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic              pkt_valid,
    output logic [LEN_W-1:0]  pkt_len,
    input  logic [ADDR_W-1:0] pkt_rd_addr,
    input  logic              pkt_rd_en,
    output logic [DATA_W-1:0] pkt_rd_data,
    input  logic              pkt_done,
    output logic [31:0]       pkt_count,
    output logic [1:0]        bank_full
);
    w_state_t          w_state, w_state_d;
    r_state_t          r_state, r_state_d;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
    logic              wr_bank, wr_bank_d;
    logic              rd_bank, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_d [2];
    logic [31:0]       count_d;
    logic              rd_seen, rd_seen_d;
    logic [DATA_W-1:0] ram_q;

    logic              accept;
    logic              release_pkt;
    logic              full_close;
    logic              flush_close;
    logic              close_bank;
    logic [LEN_W-1:0]  close_len;

    // Write and read FSMs share one next-state process because a close and a
    // release may land on the same edge; they always touch different banks.
    always_comb begin
        accept      = s_valid && (w_state != W_BLOCK);
        release_pkt = pkt_done && (r_state == R_AVAIL);
        full_close  = accept && (wr_ptr == ADDR_W'(PKT_WORDS - 1));
        flush_close = flush && ((w_state == W_FILL) || ((w_state == W_EMPTY) && accept));
        close_bank  = full_close || flush_close;
        close_len   = full_close ? LEN_W'(PKT_WORDS) : (LEN_W'(wr_ptr) + LEN_W'(accept));

        wr_ptr_d  = wr_ptr;
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        full_d    = full_q;
        len_d     = len_q;
        count_d   = pkt_count;
        rd_seen_d = rd_seen || pkt_rd_en;

        if (accept) begin
            wr_ptr_d = wr_ptr + ADDR_W'(1);
        end
        if (close_bank) begin
            full_d[wr_bank] = 1'b1;
            len_d[wr_bank]  = close_len;
            wr_ptr_d        = '0;
            wr_bank_d       = ~wr_bank;
        end
        if (release_pkt) begin
            full_d[rd_bank] = 1'b0;
            rd_bank_d       = ~rd_bank;
            count_d         = pkt_count + 32'd1;
        end

        if (full_d[wr_bank_d]) begin
            w_state_d = W_BLOCK;
        end else if (wr_ptr_d == '0) begin
            w_state_d = W_EMPTY;
        end else begin
            w_state_d = W_FILL;
        end
        r_state_d = full_d[rd_bank_d] ? R_AVAIL : R_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_EMPTY;
            r_state   <= R_EMPTY;
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full_q    <= 2'b00;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            pkt_count <= '0;
            rd_seen   <= 1'b0;
        end else begin
            w_state   <= w_state_d;
            r_state   <= r_state_d;
            wr_ptr    <= wr_ptr_d;
            wr_bank   <= wr_bank_d;
            rd_bank   <= rd_bank_d;
            full_q    <= full_d;
            len_q     <= len_d;
            pkt_count <= count_d;
            rd_seen   <= rd_seen_d;
        end
    end

    usb_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH_W(ADDR_W + 1)
    ) u_ram (
        .clk  (clk),
        .we   (accept),
        .waddr({wr_bank, wr_ptr}),
        .wdata(s_data),
        .re   (pkt_rd_en),
        .raddr({rd_bank, pkt_rd_addr}),
        .rdata(ram_q)
    );

    // The RAM read register has no reset; mask it until the first read after reset.
    assign pkt_rd_data = rd_seen ? ram_q : '0;
    assign s_ready     = (w_state != W_BLOCK);
    assign pkt_valid   = (r_state == R_AVAIL);
    assign pkt_len     = len_q[rd_bank];
    assign bank_full   = full_q;
endmodule

// File: tb/tb_usb_tx_pingpong.sv
// Directed bench for usb_tx_pingpong: streaming, back-pressure, flush, overlapping
// close/release and mid-operation reset, with hand-computed expectations.
module tb_usb_tx_pingpong;
    import usb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              flush;
    logic              pkt_valid;
    logic [LEN_W-1:0]  pkt_len;
    logic [ADDR_W-1:0] pkt_rd_addr;
    logic              pkt_rd_en;
    logic [DATA_W-1:0] pkt_rd_data;
    logic              pkt_done;
    logic [31:0]       pkt_count;
    logic [1:0]        bank_full;

    int n_assert = 0;
    int n_fail   = 0;

    usb_tx_pingpong dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .flush      (flush),
        .pkt_valid  (pkt_valid),
        .pkt_len    (pkt_len),
        .pkt_rd_addr(pkt_rd_addr),
        .pkt_rd_en  (pkt_rd_en),
        .pkt_rd_data(pkt_rd_data),
        .pkt_done   (pkt_done),
        .pkt_count  (pkt_count),
        .bank_full  (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic fl,
                                 input logic done, input logic re, input logic [ADDR_W-1:0] addr);
        s_valid     = v;
        s_data      = d;
        flush       = fl;
        pkt_done    = done;
        pkt_rd_en   = re;
        pkt_rd_addr = addr;
        @(posedge clk);
        #1;
        s_valid   = 1'b0;
        flush     = 1'b0;
        pkt_done  = 1'b0;
        pkt_rd_en = 1'b0;
    endtask

    task automatic streamWords(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 32'(base + i), 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic readWord(input string tag, input int addr, input int expected);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, ADDR_W'(addr));
        checkOutput(tag, pkt_rd_data, 32'(expected));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        checkOutput({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        checkOutput({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
        checkOutput({tag, "_rd_data"}, pkt_rd_data, 32'd0);
        checkOutput({tag, "_pkt_count"}, pkt_count, 32'd0);
        checkOutput({tag, "_bank_full"}, 32'(bank_full), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        flush       = 1'b0;
        pkt_done    = 1'b0;
        pkt_rd_en   = 1'b0;
        pkt_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] full packet streaming");
        streamWords(1, 1023);
        checkOutput("t1_valid_before_last", 32'(pkt_valid), 32'd0);
        streamWords(1024, 1);
        checkOutput("t1_valid", 32'(pkt_valid), 32'd1);
        checkOutput("t1_len", 32'(pkt_len), 32'd1024);
        checkOutput("t1_s_ready", 32'(s_ready), 32'd1);
        checkOutput("t1_bank_full", 32'(bank_full), 32'd1);
        readWord("t1_addr0", 0, 1);
        readWord("t1_addr1023", 1023, 1024);
        readWord("t1_addr511", 511, 512);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ADDR_W'(5));
        checkOutput("t1_rd_hold", pkt_rd_data, 32'd512);

        $display("[TB] back-pressure with both banks full");
        streamWords(1025, 1024);
        checkOutput("t2_s_ready_blocked", 32'(s_ready), 32'd0);
        checkOutput("t2_bank_full", 32'(bank_full), 32'd3);
        streamWords(2049, 3);
        checkOutput("t2_still_blocked", 32'(s_ready), 32'd0);
        checkOutput("t2_len_bank0", 32'(pkt_len), 32'd1024);
        applyStimulus(1'b1, 32'd2049, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t2_s_ready_after_done", 32'(s_ready), 32'd1);
        checkOutput("t2_count", pkt_count, 32'd1);
        checkOutput("t2_valid_bank1", 32'(pkt_valid), 32'd1);
        checkOutput("t2_bank_full_after_done", 32'(bank_full), 32'd2);
        streamWords(2049, 1);
        readWord("t2_bank1_addr0", 0, 1025);
        readWord("t2_bank1_addr1023", 1023, 2048);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("t2_flush_blocks", 32'(s_ready), 32'd0);
        checkOutput("t2_flush_full", 32'(bank_full), 32'd3);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t2_count2", pkt_count, 32'd2);
        checkOutput("t2_len_one", 32'(pkt_len), 32'd1);
        checkOutput("t2_s_ready_free", 32'(s_ready), 32'd1);
        readWord("t2_word2049", 0, 2049);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t2_count3", pkt_count, 32'd3);
        checkOutput("t2_empty", 32'(pkt_valid), 32'd0);

        $display("[TB] short packets via flush");
        streamWords(11, 4);
        applyStimulus(1'b1, 32'd15, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("t3_valid", 32'(pkt_valid), 32'd1);
        checkOutput("t3_len_accept_flush", 32'(pkt_len), 32'd5);
        readWord("t3_addr0", 0, 11);
        readWord("t3_addr4", 4, 15);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("t3_empty_flush", 32'(bank_full), 32'd2);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t3_count4", pkt_count, 32'd4);
        checkOutput("t3_no_packet", 32'(pkt_valid), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t3_done_ignored", pkt_count, 32'd4);
        streamWords(21, 5);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("t3b_len", 32'(pkt_len), 32'd5);
        readWord("t3b_addr2", 2, 23);
        readWord("t3b_addr4", 4, 25);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 32'd77, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("t3c_one_word_len", 32'(pkt_len), 32'd1);
        checkOutput("t3c_bank_full", 32'(bank_full), 32'd2);
        readWord("t3c_addr0", 0, 77);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t3c_count6", pkt_count, 32'd6);

        $display("[TB] release and close on the same edge");
        streamWords(1000, 1024);
        streamWords(5000, 1023);
        applyStimulus(1'b1, 32'd6023, 1'b1, 1'b1, 1'b0, '0);
        checkOutput("t4_valid", 32'(pkt_valid), 32'd1);
        checkOutput("t4_len", 32'(pkt_len), 32'd1024);
        checkOutput("t4_count", pkt_count, 32'd7);
        checkOutput("t4_bank_full", 32'(bank_full), 32'd2);
        checkOutput("t4_s_ready", 32'(s_ready), 32'd1);
        readWord("t4_addr0", 0, 5000);
        readWord("t4_addr1023", 1023, 6023);

        $display("[TB] reset mid-operation");
        streamWords(9000, 300);
        rst_n = 1'b0;
        #1;
        checkResetState("t5_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        streamWords(3000, 1024);
        checkOutput("t5_valid", 32'(pkt_valid), 32'd1);
        checkOutput("t5_len", 32'(pkt_len), 32'd1024);
        checkOutput("t5_bank_full", 32'(bank_full), 32'd1);
        readWord("t5_addr0", 0, 3000);
        readWord("t5_addr299", 299, 3299);
        readWord("t5_addr1023", 1023, 4023);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t5_count", pkt_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
